// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam logic [31:0] END_WORD_DEFAULT = 32'h0000_0FFF;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer plus bit-timing FSM.
module uart_rx
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 347
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync_q;
    logic          rx_s;
    rx_state_e     state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    byte_q;
    logic          valid_q;
    logic          ferr_q;

    assign rx_s = sync_q[1];

    // Two-stage synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    // Receive FSM with registered byte/strobe outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RX_IDLE;
            timer_q   <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            byte_q    <= 8'h00;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state_q <= RX_START;
                        timer_q <= '0;
                    end
                end
                RX_START: begin
                    if (timer_q == HALF_END) begin
                        timer_q   <= '0;
                        bit_idx_q <= 3'd0;
                        state_q   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RX_DATA: begin
                    if (timer_q == BIT_END) begin
                        timer_q   <= '0;
                        shift_q   <= {rx_s, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RX_STOP: begin
                    if (timer_q == BIT_END) begin
                        timer_q <= '0;
                        state_q <= RX_IDLE;
                        if (rx_s) begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Streams a little-endian program image from UART into instruction memory,
// holding the core in reset until the end-of-image marker word arrives.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 347,
    parameter int unsigned ADDR_W       = 10,
    parameter logic [31:0] END_WORD     = END_WORD_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rx_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              core_rst_no,
    output logic              done_o,
    output logic              err_o
);

    logic [7:0]        rx_byte_s;
    logic              byte_valid_s;
    logic              frame_err_s;
    logic [31:0]       full_word_s;

    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       word_q, word_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [ADDR_W-1:0] addr_out_q, addr_out_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_i        (rx_i),
        .byte_o      (rx_byte_s),
        .byte_valid_o(byte_valid_s),
        .frame_err_o (frame_err_s)
    );

    // Word assembly and write decision; addr_q carries an extra MSB so overflow never wraps.
    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        addr_out_d  = addr_out_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        done_d      = done_q;
        err_d       = err_q | frame_err_s;
        full_word_s = {rx_byte_s, word_q[23:0]};
        if (we_q) begin
            addr_d = addr_q + {{ADDR_W{1'b0}}, 1'b1};
        end else begin
            addr_d = addr_q;
        end
        if (byte_valid_s && !done_q) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    word_d[7:0]   = rx_byte_s;
                2'd1:    word_d[15:8]  = rx_byte_s;
                2'd2:    word_d[23:16] = rx_byte_s;
                default: word_d[31:24] = rx_byte_s;
            endcase
            if (byte_cnt_q == 2'd3) begin
                if (full_word_s == END_WORD) begin
                    done_d = 1'b1;
                end else if (!addr_q[ADDR_W]) begin
                    we_d       = 1'b1;
                    addr_out_d = addr_q[ADDR_W-1:0];
                    wdata_d    = full_word_s;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                we_d = 1'b0;
            end
        end else begin
            byte_cnt_d = byte_cnt_q;
        end
    end

    // Loader state and registered memory/reset outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt_q <= 2'd0;
            word_q     <= 32'h0000_0000;
            addr_q     <= '0;
            addr_out_q <= '0;
            wdata_q    <= 32'h0000_0000;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            addr_out_q <= addr_out_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_out_q;
    assign imem_wdata_o = wdata_q;
    assign core_rst_no  = done_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader at 16 clocks/bit with a 4-word memory.
module tb_uart_prog_loader;

    localparam int unsigned CPB = 16;
    localparam int unsigned AW  = 2;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          rx = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst_n;
    logic          done;
    logic          err;

    int nvec = 0;
    int nerr = 0;
    int          wr_addr[$];
    logic [31:0] wr_data[$];

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .rx_i        (rx),
        .imem_we_o   (imem_we),
        .imem_addr_o (imem_addr),
        .imem_wdata_o(imem_wdata),
        .core_rst_no (core_rst_n),
        .done_o      (done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Every strobed cycle is logged, so a strobe longer than one cycle shows up as extra writes.
    always @(negedge clk) begin
        if (rst_ni && imem_we) begin
            wr_addr.push_back(int'(imem_addr));
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        if (!stop_bit) begin
            repeat (2 * CPB) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], 1'b1);
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        rst_ni = 1'b1;
        idle(4);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", {30'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        // Single word DEADBEEF
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        idle(40);
        chk("w1_count", wr_addr.size(), 32'd1);
        chk("w1_addr", wr_addr[0], 32'd0);
        chk("w1_data", wr_data[0], 32'hDEADBEEF);
        chk("w1_held_data", imem_wdata, 32'hDEADBEEF);
        chk("w1_core_rst_n", {31'd0, core_rst_n}, 32'd0);

        // 4-cycle glitch is rejected silently
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(60);
        chk("glitch_count", wr_addr.size(), 32'd1);
        chk("glitch_err", {31'd0, err}, 32'd0);

        // Image of two words plus marker
        do_reset();
        send_word(32'h0000_0013);
        send_word(32'h0010_0093);
        send_word(32'h0000_0FFF);
        idle(40);
        chk("img_count", wr_addr.size(), 32'd2);
        chk("img_addr0", wr_addr[0], 32'd0);
        chk("img_data0", wr_data[0], 32'h0000_0013);
        chk("img_addr1", wr_addr[1], 32'd1);
        chk("img_data1", wr_data[1], 32'h0010_0093);
        chk("img_done", {31'd0, done}, 32'd1);
        chk("img_core_rst_n", {31'd0, core_rst_n}, 32'd1);
        chk("img_err", {31'd0, err}, 32'd0);
        send_word(32'hAABB_CCDD);
        idle(40);
        chk("post_done_count", wr_addr.size(), 32'd2);
        chk("post_done_addr", {30'd0, imem_addr}, 32'd1);

        // Framing error keeps the byte count: 78 56 <bad> 34 12 -> 12345678
        do_reset();
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'hAA, 1'b0);
        idle(4);
        chk("ferr_err", {31'd0, err}, 32'd1);
        chk("ferr_no_write", wr_addr.size(), 32'd0);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        idle(40);
        chk("ferr_count", wr_addr.size(), 32'd1);
        chk("ferr_data", wr_data[0], 32'h1234_5678);

        // Reset mid-word discards the partial word
        do_reset();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rst_ni = 1'b0;
        #3;
        chk("midrst_err", {31'd0, err}, 32'd0);
        chk("midrst_wdata", imem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        idle(4);
        send_word(32'h1234_5678);
        idle(40);
        chk("midrst_count", wr_addr.size(), 32'd1);
        chk("midrst_addr", wr_addr[0], 32'd0);
        chk("midrst_data", wr_data[0], 32'h1234_5678);

        // Address overflow with a 4-word memory
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send_word(32'h0000_0100 + 32'(i));
        end
        idle(40);
        chk("ovf_err_before", {31'd0, err}, 32'd0);
        send_word(32'h0000_0105);
        idle(40);
        chk("ovf_count", wr_addr.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_addr", wr_addr[i], 32'(i));
            chk("ovf_data", wr_data[i], 32'h0000_0101 + 32'(i));
        end
        chk("ovf_err", {31'd0, err}, 32'd1);
        chk("ovf_done", {31'd0, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

User-project block that receives the program image streamed over the user-area serial pin after `mprj_ready` rises, assembles bytes into 32-bit little-endian words, and writes them sequentially into the core's instruction memory. It holds the core in reset until the end-of-image marker arrives, then releases it. It sits directly downstream of the serial programming pin and upstream of the instruction memory write port and core reset.

## Interface

Parameters:
- `CLKS_PER_BIT`, 347, clock cycles per UART bit (40 MHz / 115200); must be ≥ 4
- `ADDR_W`, 10, instruction-memory word-address width
- `END_WORD`, 32'h0000_0FFF, end-of-image marker; never written to memory

Ports:
- `clk_i`  in  1  single clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `rx_i`  in  1  UART serial input, 8N1, idle high, asynchronous to `clk_i`
- `imem_we_o`  out  1  one-cycle write strobe
- `imem_addr_o`  out  ADDR_W  word address of current write
- `imem_wdata_o`  out  32  write data
- `core_rst_no`  out  1  core reset, low until image complete
- `done_o`  out  1  sticky, image loaded
- `err_o`  out  1  sticky, framing error or address overflow

## Operation

- `rx_i` passes a 2-flop synchronizer (reset value 1); all logic uses the synchronized bit.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: on synchronized low, go START, clear bit timer.
  - START: at timer = CLKS_PER_BIT/2 − 1 (integer division), sample; low → DATA, timer cleared; high → IDLE (glitch rejected, nothing reported).
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, into shift register; after bit 7 go STOP.
  - STOP: after CLKS_PER_BIT cycles sample; high → one-cycle internal `byte_valid`; low → set `err_o`, byte discarded. Either way → IDLE.
- Loader: 2-bit byte counter; byte k fills bits [8k+7:8k] (first byte → [7:0]).
- On 4th byte: word == END_WORD → set `done_o`, raise `core_rst_no`, ignore all further input; else if address < 2^ADDR_W → write, address +1; else drop word, set `err_o`.
- Framing error does not reset the byte counter; the word simply completes one byte later (image is corrupt; `err_o` flags it).
- After `done_o`, RX FSM may keep running but loader takes no action.

## Timing

- Reset values: `imem_we_o`=0, `imem_addr_o`=0, `imem_wdata_o`=0, `core_rst_no`=0, `done_o`=0, `err_o`=0; byte counter, address, FSM (IDLE) cleared.
- Latency: falling edge on `rx_i` to START entry = 3 cycles (2 sync + 1 FSM).
- `byte_valid` is the cycle after the stop-bit sample; `imem_we_o` is registered, high exactly one cycle, the cycle after the 4th `byte_valid`, with `imem_addr_o`/`imem_wdata_o` valid that same cycle and held until the next write.
- Address increments the cycle after the strobe; internal address is ADDR_W+1 bits so overflow is detectable (no wrap to 0).
- `done_o` and `core_rst_no` rise together, cycle after the 4th byte of the marker; no write strobe that cycle.
- Back-to-back frames (stop bit immediately followed by start) must be received without loss.
- Reset mid-frame or mid-word: everything returns to reset values asynchronously; partial byte/word discarded.

## Structure

- Shared package: FSM state enum (`rx_state_e`), default `END_WORD` constant.
- One natural sub-module: `uart_rx` (synchronizer + RX FSM, outputs `byte_o`, `byte_valid_o`, `frame_err_o`); loader logic in the top.

## Test plan

- Bytes EF BE AD DE at CLKS_PER_BIT=16 → one strobe, addr 0, data 32'hDEADBEEF; `core_rst_no` still 0.
- Three words 0x00000013, 0x00100093, 0x00000FFF back-to-back → writes addr 0 and 1 only; then `done_o`=1, `core_rst_no`=1; further bytes produce no strobe.
- `rx_i` low for 4 cycles only (CLKS_PER_BIT=16) → no byte, no strobe, `err_o`=0.
- Frame with stop bit low → `err_o`=1, byte counter unchanged.
- ADDR_W=2, five non-marker words → writes addr 0..3, fifth dropped, `err_o`=1.
- Assert `rst_ni` low after 2 bytes of a word, release, send full word 0x12345678 → single write addr 0 data 32'h12345678.
